// File: rtl/alu_iter.sv
// Iterative ALU: single-cycle arithmetic/logic ops and bit-serial shifts/rotates.
// Optional nibble-wise BCD for ADC/SBC when ALU_DECIMAL_MODE_EN is defined.
module alu_iter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] accumulator,
    input  logic [WIDTH-1:0] operand_2,
    input  logic [7:0]       status,
    output logic [WIDTH-1:0] result,
    output logic [7:0]       status_out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    // Handshake: start is accepted on a rising edge whenever busy=0 (including
    // the cycle in which done=1); done pulses once per accepted start.

    localparam logic [3:0] OP_ADC = 4'd0;
    localparam logic [3:0] OP_SBC = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_ORA = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_ASL = 4'd5;
    localparam logic [3:0] OP_LSR = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;
    localparam logic [3:0] OP_INC = 4'd9;
    localparam logic [3:0] OP_DEC = 4'd10;
    localparam logic [3:0] OP_CMP = 4'd11;
    localparam logic [3:0] OP_BIT = 4'd12;

    localparam int F_N = 7;
    localparam int F_V = 6;
    localparam int F_Z = 1;
    localparam int F_C = 0;

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] N_MAX   = WIDTH'(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [3:0]       sh_op;
    logic [WIDTH-1:0] sreg;
    logic             sh_c;
    logic [WIDTH-1:0] cnt;
    logic [7:0]       st_q;

    logic             is_shift;
    logic [WIDTH-1:0] n_sh;
    logic             accept;
    logic             start_shift;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             v_bin;
    logic [WIDTH-1:0] ar_res;
    logic             ar_c;
    logic [WIDTH-1:0] imm_res;
    logic [7:0]       imm_st;

    logic [WIDTH-1:0] sh_next;
    logic             sh_out;
    logic [7:0]       fin_st;

    assign is_shift    = (op >= OP_ASL) && (op <= OP_ROR);
    assign n_sh        = (operand_2 > N_MAX) ? N_MAX : operand_2;
    assign busy        = (state == SHIFT);
    assign accept      = start && !busy;
    assign start_shift = is_shift && (n_sh != '0);
    assign state_dbg   = state;

    // Binary add path shared by ADC and SBC (SBC adds the inverted operand).
    assign b_eff = (op == OP_SBC) ? ~operand_2 : operand_2;
    assign sum   = {1'b0, accumulator} + {1'b0, b_eff} + {{WIDTH{1'b0}}, status[F_C]};
    assign diff  = {1'b0, accumulator} - {1'b0, operand_2};
    assign v_bin = (accumulator[WIDTH-1] == b_eff[WIDTH-1]) &&
                   (sum[WIDTH-1] != accumulator[WIDTH-1]);

`ifdef ALU_DECIMAL_MODE_EN
    logic [WIDTH-1:0] bcd_res;
    logic             bcd_c;

    // Digit-serial BCD; for SBC the running carry is a borrow.
    always_comb begin
        logic       cy;
        logic [4:0] t;
        bcd_res = '0;
        t       = '0;
        cy      = (op == OP_SBC) ? ~status[F_C] : status[F_C];
        for (int i = 0; i < WIDTH / 4; i++) begin
            if (op == OP_SBC) begin
                t = {1'b0, accumulator[4*i +: 4]} - {1'b0, operand_2[4*i +: 4]} - {4'b0, cy};
                if (t[4]) begin
                    t  = t - 5'd6;
                    cy = 1'b1;
                end else begin
                    cy = 1'b0;
                end
            end else begin
                t = {1'b0, accumulator[4*i +: 4]} + {1'b0, operand_2[4*i +: 4]} + {4'b0, cy};
                if (t > 5'd9) begin
                    t  = t + 5'd6;
                    cy = 1'b1;
                end else begin
                    cy = 1'b0;
                end
            end
            bcd_res[4*i +: 4] = t[3:0];
        end
        bcd_c = (op == OP_SBC) ? ~cy : cy;
    end

    assign ar_res = status[3] ? bcd_res : sum[WIDTH-1:0];
    assign ar_c   = status[3] ? bcd_c   : sum[WIDTH];
`else
    assign ar_res = sum[WIDTH-1:0];
    assign ar_c   = sum[WIDTH];
`endif

    // Results of every op that completes without iterating.
    always_comb begin
        imm_res = accumulator;
        imm_st  = status;
        case (op)
            OP_ADC, OP_SBC: begin
                imm_res     = ar_res;
                imm_st[F_C] = ar_c;
                imm_st[F_V] = v_bin;
                imm_st[F_N] = ar_res[WIDTH-1];
                imm_st[F_Z] = (ar_res == '0);
            end
            OP_AND, OP_ORA, OP_EOR, OP_INC, OP_DEC: begin
                case (op)
                    OP_AND:  imm_res = accumulator & operand_2;
                    OP_ORA:  imm_res = accumulator | operand_2;
                    OP_EOR:  imm_res = accumulator ^ operand_2;
                    OP_INC:  imm_res = accumulator + CNT_ONE;
                    default: imm_res = accumulator - CNT_ONE;
                endcase
                imm_st[F_N] = imm_res[WIDTH-1];
                imm_st[F_Z] = (imm_res == '0);
            end
            OP_ASL, OP_LSR, OP_ROL, OP_ROR: begin
                imm_st[F_N] = accumulator[WIDTH-1];
                imm_st[F_Z] = (accumulator == '0);
            end
            OP_CMP: begin
                imm_st[F_C] = ~diff[WIDTH];
                imm_st[F_N] = diff[WIDTH-1];
                imm_st[F_Z] = (diff[WIDTH-1:0] == '0);
            end
            OP_BIT: begin
                imm_st[F_Z] = ((accumulator & operand_2) == '0);
                imm_st[F_N] = operand_2[WIDTH-1];
                imm_st[F_V] = operand_2[WIDTH-2];
            end
            default: begin
                imm_res = accumulator;
                imm_st  = status;
            end
        endcase
    end

    // One bit position per cycle; rotates go through the latched carry.
    always_comb begin
        sh_next = sreg;
        sh_out  = sh_c;
        case (sh_op)
            OP_ASL: begin
                sh_next = {sreg[WIDTH-2:0], 1'b0};
                sh_out  = sreg[WIDTH-1];
            end
            OP_LSR: begin
                sh_next = {1'b0, sreg[WIDTH-1:1]};
                sh_out  = sreg[0];
            end
            OP_ROL: begin
                sh_next = {sreg[WIDTH-2:0], sh_c};
                sh_out  = sreg[WIDTH-1];
            end
            default: begin
                sh_next = {sh_c, sreg[WIDTH-1:1]};
                sh_out  = sreg[0];
            end
        endcase
        fin_st      = st_q;
        fin_st[F_C] = sh_out;
        fin_st[F_N] = sh_next[WIDTH-1];
        fin_st[F_Z] = (sh_next == '0);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, EXEC: begin
                if (accept) state_nx = start_shift ? SHIFT : EXEC;
                else        state_nx = IDLE;
            end
            SHIFT: begin
                if (cnt == CNT_ONE) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result     <= '0;
            status_out <= '0;
            done       <= 1'b0;
            sh_op      <= '0;
            sreg       <= '0;
            sh_c       <= 1'b0;
            cnt        <= '0;
            st_q       <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                if (start_shift) begin
                    sh_op <= op;
                    sreg  <= accumulator;
                    sh_c  <= status[F_C];
                    cnt   <= n_sh;
                    st_q  <= status;
                end else begin
                    result     <= imm_res;
                    status_out <= imm_st;
                    done       <= 1'b1;
                end
            end else if (state == SHIFT) begin
                sreg <= sh_next;
                sh_c <= sh_out;
                cnt  <= cnt - CNT_ONE;
                // Only the final shift value reaches the result register.
                if (cnt == CNT_ONE) begin
                    result     <= sh_next;
                    status_out <= fin_st;
                    done       <= 1'b1;
                end
            end
        end
    end

endmodule
